// File: rtl/rf_wb_arbiter_if.sv
// Register-file write port bundle: pipeline writeback slot,
// multi-cycle result channel and the resulting RF write controls.
interface rf_wb_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic        wb_stall;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [1:0]  rf_wr_sel;
  logic        rf_wd_src;
  logic [31:0] mc_wd;

  modport master (
    output wb_valid, wb_rd, wb_sel,
    output mc_valid, mc_rd, mc_data,
    input  wb_stall, mc_ready,
    input  rf_we, rf_wa, rf_wr_sel,
    input  rf_wd_src, mc_wd
  );

  modport slave (
    input  wb_valid, wb_rd, wb_sel,
    input  mc_valid, mc_rd, mc_data,
    output wb_stall, mc_ready,
    output rf_we, rf_wa, rf_wr_sel,
    output rf_wd_src, mc_wd
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the single RF write port between the writeback slot
// and a buffered multi-cycle result stream with starvation limit.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } state_t;

  state_t state, state_nxt;

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_after;
  logic [CW-1:0] starve_cnt, starve_nxt;

  logic full, wb_req, enq, mc_grant;

  assign full   = count == (AW+1)'(DEPTH);
  assign wb_req = bus.wb_valid & (bus.wb_rd != 5'd0);
  // x0 results are accepted but dropped on the floor
  assign enq    = bus.mc_valid & ~full
                & (bus.mc_rd != 5'd0);

  assign count_after = count
                     + (AW+1)'(enq)
                     - (AW+1)'(mc_grant);

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    mc_grant   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enq) state_nxt = PEND;
      end
      PEND: begin
        if (full) begin
          mc_grant = 1'b1;
        end else if (wb_req) begin
          starve_nxt = starve_cnt + 1'b1;
          if (starve_nxt == CW'(STARVE_MAX))
            state_nxt = FORCE;
        end else begin
          mc_grant = 1'b1;
        end
      end
      FORCE: begin
        mc_grant = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (mc_grant) begin
      starve_nxt = '0;
      state_nxt  = (count_after != '0) ? PEND : IDLE;
    end
  end

  assign bus.mc_ready  = ~full;
  assign bus.wb_stall  = mc_grant & wb_req;
  assign bus.rf_we     = mc_grant | wb_req;
  assign bus.rf_wa     = mc_grant ? fifo_rd[rd_ptr]
                                  : bus.wb_rd;
  assign bus.rf_wr_sel = mc_grant ? 2'b11 : bus.wb_sel;
  assign bus.rf_wd_src = mc_grant;
  assign bus.mc_wd     = mc_grant ? fifo_data[rd_ptr]
                                  : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      count      <= count_after;
      if (enq)      wr_ptr <= wr_ptr + 1'b1;
      if (mc_grant) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[wr_ptr]   <= bus.mc_rd;
      fifo_data[wr_ptr] <= bus.mc_data;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter: expected RF
// writes are queued with their cycle and checked by a monitor.
module tb_rf_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] pend = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(
    .DEPTH(2),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  wa;
    logic        src;
    logic [1:0]  sel;
    logic [31:0] wd;
    logic        stall;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic wv,
                       input logic [4:0] wrd,
                       input logic [1:0] wsel,
                       input logic mv,
                       input logic [4:0] mrd,
                       input logic [31:0] md);
    bus.wb_valid = wv;
    bus.wb_rd    = wrd;
    bus.wb_sel   = wsel;
    bus.mc_valid = mv;
    bus.mc_rd    = mrd;
    bus.mc_data  = md;
    if (mv && mrd != 5'd0) pend[mrd] = 1'b1;
  endtask

  task automatic idle;
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wb(input int off,
                        input logic [4:0] wa,
                        input logic [1:0] sel);
    exp_t e;
    e = '{cyc + off, wa, 1'b0, sel, 32'h0, 1'b0};
    sb.push_back(e);
  endtask

  task automatic exp_mc(input int off,
                        input logic [4:0] wa,
                        input logic [31:0] wd,
                        input logic stall);
    exp_t e;
    e = '{cyc + off, wa, 1'b1, 2'b11, wd, stall};
    sb.push_back(e);
    pend[wa] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wb_valid && bus.wb_rd != 5'd0)
        assert (!pend[bus.wb_rd])
          else $error("rd hazard on x%0d", bus.wb_rd);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missing_write", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (bus.rf_we) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {27'h0, bus.rf_wa},
              32'hffffffff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("rf_wa", 32'(bus.rf_wa), 32'(e.wa));
          chk("rf_wd_src", 32'(bus.rf_wd_src),
              32'(e.src));
          chk("rf_wr_sel", 32'(bus.rf_wr_sel),
              32'(e.sel));
          chk("wb_stall", 32'(bus.wb_stall),
              32'(e.stall));
          if (e.src) chk("mc_wd", bus.mc_wd, e.wd);
        end
      end else begin
        chk("stall_no_write", 32'(bus.wb_stall), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    tick();
    tick();
    chk("rst_ready", 32'(bus.mc_ready), 1);
    chk("rst_we", 32'(bus.rf_we), 0);
    chk("rst_stall", 32'(bus.wb_stall), 0);
    chk("rst_wd", bus.mc_wd, 0);
    rst_n = 1'b1;
    tick();

    // WB only
    drive(1'b1, 5'd5, 2'b10, 1'b0, 5'd0, 32'h0);
    exp_wb(0, 5'd5, 2'b10);
    #1 chk("t2_stall", 32'(bus.wb_stall), 0);
    tick();

    // MC only, one-cycle latency
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd7, 32'hdeadbeef);
    exp_mc(1, 5'd7, 32'hdeadbeef, 1'b0);
    tick();
    idle();
    tick();
    chk("t3_idle_we", 32'(bus.rf_we), 0);
    chk("t3_ready", 32'(bus.mc_ready), 1);
    tick();

    // starvation: 1 IDLE + 4 PEND WB writes, then forced MC
    drive(1'b1, 5'd3, 2'b11, 1'b1, 5'd9, 32'h11);
    for (int i = 0; i < 5; i++) exp_wb(i, 5'd3, 2'b11);
    exp_mc(5, 5'd9, 32'h11, 1'b1);
    exp_wb(6, 5'd3, 2'b11);
    tick();
    drive(1'b1, 5'd3, 2'b11, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_stall", 32'(bus.wb_stall), 1);
    tick();
    chk("t4_resume", 32'(bus.wb_stall), 0);
    tick();
    idle();
    tick();

    // full FIFO forces MC grant
    drive(1'b1, 5'd4, 2'b01, 1'b1, 5'd10, 32'ha0a0a0a0);
    exp_wb(0, 5'd4, 2'b01);
    tick();
    drive(1'b1, 5'd4, 2'b01, 1'b1, 5'd11, 32'hb0b0b0b0);
    exp_wb(0, 5'd4, 2'b01);
    exp_mc(1, 5'd10, 32'ha0a0a0a0, 1'b1);
    exp_wb(2, 5'd4, 2'b01);
    exp_mc(3, 5'd11, 32'hb0b0b0b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 2'b01, 1'b0, 5'd0, 32'h0);
    #1 chk("t5_full_ready", 32'(bus.mc_ready), 0);
    chk("t5_stall", 32'(bus.wb_stall), 1);
    tick();
    chk("t5_ready_back", 32'(bus.mc_ready), 1);
    tick();
    idle();
    tick();

    // x0 handling
    drive(1'b0, 5'd0, 2'd0, 1'b1, 5'd0, 32'h55);
    tick();
    idle();
    #1 chk("t6_x0_we", 32'(bus.rf_we), 0);
    tick();
    drive(1'b1, 5'd0, 2'd0, 1'b1, 5'd12, 32'h66);
    exp_mc(1, 5'd12, 32'h66, 1'b0);
    tick();
    drive(1'b1, 5'd0, 2'b10, 1'b0, 5'd0, 32'h0);
    #1 chk("t6_stall", 32'(bus.wb_stall), 0);
    chk("t6_we", 32'(bus.rf_we), 1);
    tick();
    idle();
    tick();

    // reset with two entries queued
    drive(1'b1, 5'd6, 2'b00, 1'b1, 5'd13, 32'hd1);
    exp_wb(0, 5'd6, 2'b00);
    tick();
    drive(1'b1, 5'd6, 2'b00, 1'b1, 5'd14, 32'hd2);
    exp_wb(0, 5'd6, 2'b00);
    tick();
    idle();
    rst_n = 1'b0;
    pend = '0;
    #1 chk("t1_ready", 32'(bus.mc_ready), 1);
    chk("t1_we", 32'(bus.rf_we), 0);
    chk("t1_wd", bus.mc_wd, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd2, 2'b01, 1'b0, 5'd0, 32'h0);
    exp_wb(0, 5'd2, 2'b01);
    #1 chk("t1_post_ready", 32'(bus.mc_ready), 1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
